gshare_predictor: RTL
=====================

// Module: gshare_predictor
// PURPOSE
//  Parametrised gshare direction predictor, successor to the fixed 64-entry 2-bit bimodal table.
//  - Indexes a table of CNT_W-bit saturating counters with PC[IDX_W+1:2] XOR the global history.
//  - Sits between the instruction unit (lookup) and the ROB (commit-time training).
//  - Optionally adds a direct-mapped BTB for the predicted target.
// PARAMETERS
//  IDX_W   6   log2 of PHT entries; PHT_SIZE = 2**IDX_W
//  HIST_W  6   global history bits, 1..IDX_W; zero-extended into the XOR
//  CNT_W   2   counter width, 2..4
//  BTB_W   4   log2 of BTB entries (used only with BP_BTB_EN)
// PORTS
//  clockIn       in   1       clock
//  resetIn       in   1       asynchronous, active-high reset
//  readyIn       in   1       global enable; low freezes all state and outputs
//  predictReq    in   1       lookup request from the instruction unit
//  predictAddr   in   32      PC to predict
//  predictValid  out  1       registered; result below is valid
//  predictTaken  out  1       predicted direction
//  predictIdx    out  IDX_W   PHT index used; carried with the instruction to the ROB
//  predictTarget out  32      BTB target (0 without BP_BTB_EN)
//  btbHit        out  1       BTB tag match (0 without BP_BTB_EN)
//  updateFlag    in   1       ROB commits a conditional branch
//  updateIdx     in   IDX_W   predictIdx returned by the ROB
//  updateAddr    in   32      branch PC (BTB index/tag)
//  updateTaken   in   1       resolved direction
//  updateTarget  in   32      resolved target
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-operation):
//    - every counter <= 1<<(CNT_W-1) (weakly taken); ghr <= 0; all BTB valid bits <= 0.
//    - predictValid, predictTaken, predictIdx, predictTarget and btbHit <= 0.
//  - Lookup: idx = predictAddr[IDX_W+1:2] ^ {{(IDX_W-HIST_W){1'b0}}, ghr}.
//    At a rising edge with readyIn && predictReq:
//      predictValid <= 1; predictIdx <= idx; predictTaken <= pht[idx][CNT_W-1].
//    At a rising edge with readyIn && !predictReq: predictValid <= 0; other outputs hold.
//    Latency is exactly 1 cycle; no back-pressure; one lookup per cycle.
//  - Update, at a rising edge with readyIn && updateFlag:
//    - pht[updateIdx] saturating: taken -> +1 capped at 2**CNT_W-1; not-taken -> -1 floored at 0.
//    - ghr <= {ghr[HIST_W-2:0], updateTaken}. History is committed-only, so no flush repair is needed.
//  - Simultaneous lookup and update:
//    - Read-before-write: the lookup sees the pre-update counter and the pre-shift ghr, even when idx == updateIdx.
//  - readyIn low: no counter, history, BTB or output changes, regardless of predictReq or updateFlag.
//  - Saturation boundaries:
//    - CNT_W=2: 11 + taken stays 11; 00 + not-taken stays 00.
//    - Index wrap-around is natural truncation to IDX_W bits.
// CONFIGURATION
//  BP_BTB_EN defined:
//    - BTB has 2**BTB_W entries of {valid, tag = addr[31:BTB_W+2], target}, indexed by addr[BTB_W+1:2].
//    - Lookup, same edge as the PHT: btbHit <= valid && tag match; predictTarget <= target on a hit, else 0.
//    - On an update with updateTaken=1 the entry is written {1, tag, updateTarget}. Not-taken updates leave it untouched.
//    - Same-edge lookup and write: the lookup sees the old entry.
//  BP_BTB_EN undefined:
//    - No BTB storage; predictTarget and btbHit are tied to 0.
// STRUCTURE
//  - Shared header bp_defs.vh: counter-reset and saturation constants, the index-hash macro, and the BTB entry field widths. The ROB uses the same header to size its predictIdx field.
//  - One sub-module, bp_btb: BTB storage plus tag compare, instantiated only under BP_BTB_EN.
//  - PHT update logic stays inline in this module.
// TESTING
//  1. Reset, then lookup with PC=0x100 -> next cycle predictValid=1, predictTaken=1, predictIdx=0x00.
//  2. Four not-taken updates to idx 0x10 -> counter 00; a further not-taken keeps 00;
//     a lookup mapping to 0x10 gives taken=0; two taken updates -> taken=1.
//  3. Updates with taken=1,0,1 from reset -> ghr=6'b000101;
//     lookup PC=0x100 -> predictIdx = 0x00 ^ 0x05 = 0x05.
//  4. Same-edge lookup and update on idx 0x05, counter 01, update taken
//     -> predictTaken=0 (old value); the next lookup gives 1.
//  5. readyIn=0 with predictReq=1 and updateFlag=1 for 3 cycles -> outputs, ghr and counters unchanged.
//     Assert resetIn mid-stream -> outputs are 0 immediately, without waiting for a clock edge.
//  6. BP_BTB_EN: taken update PC=0x204, target 0x400; lookup 0x204 -> btbHit=1, target=0x400;
//     lookup 0x244 (same BTB index, different tag) -> btbHit=0, target=0.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared constants and helpers for the gshare predictor: counter reset/saturation,
// index hash, and address width used by the optional BTB.
package gshare_predictor_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned MaxCntW = 4;

  typedef logic [MaxCntW-1:0] cnt_t;

  // Weakly-taken reset value: only the counter MSB set.
  function automatic cnt_t cnt_reset(input int unsigned cnt_w);
    return cnt_t'(1 << (cnt_w - 1));
  endfunction

  function automatic cnt_t cnt_max(input int unsigned cnt_w);
    return cnt_t'((1 << cnt_w) - 1);
  endfunction

  function automatic cnt_t cnt_step(input cnt_t cnt, input logic taken, input cnt_t max);
    if (taken) begin
      return (cnt == max) ? cnt : cnt + cnt_t'(1);
    end
    return (cnt == '0) ? cnt : cnt - cnt_t'(1);
  endfunction

  // Word-aligned PC bits XOR zero-extended history, truncated to idx_w bits.
  function automatic logic [AddrW-1:0] gshare_hash(input logic [AddrW-1:0] pc,
                                                   input logic [AddrW-1:0] hist,
                                                   input int unsigned idx_w);
    logic [AddrW-1:0] mask;
    mask = AddrW'((64'd1 << idx_w) - 64'd1);
    return ((pc >> 2) ^ hist) & mask;
  endfunction

endpackage

// File: rtl/gshare_predictor_btb.sv
// Direct-mapped branch target buffer with registered tag compare; the lookup
// sees the entry as it was before a same-edge write.
module gshare_predictor_btb
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned BTB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_en,
  input  logic [AddrW-1:0] lookup_addr,
  output logic             hit,
  output logic [AddrW-1:0] target,
  input  logic             write_en,
  input  logic [AddrW-1:0] write_addr,
  input  logic [AddrW-1:0] write_target
);

  localparam int unsigned Entries = 2 ** BTB_W;
  localparam int unsigned TagW    = AddrW - BTB_W - 2;

  logic [Entries-1:0] valid_q;
  logic [TagW-1:0]    tag_q    [Entries];
  logic [AddrW-1:0]   target_q [Entries];

  logic [BTB_W-1:0] rd_idx, wr_idx;
  logic [TagW-1:0]  rd_tag, wr_tag;
  logic             rd_match;
  logic             unused_low;

  assign rd_idx     = lookup_addr[BTB_W+1:2];
  assign rd_tag     = lookup_addr[AddrW-1:BTB_W+2];
  assign wr_idx     = write_addr[BTB_W+1:2];
  assign wr_tag     = write_addr[AddrW-1:BTB_W+2];
  assign rd_match   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign unused_low = ^{lookup_addr[1:0], write_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      hit     <= 1'b0;
      target  <= '0;
    end else begin
      if (lookup_en) begin
        hit    <= rd_match;
        target <= rd_match ? target_q[rd_idx] : '0;
      end
      if (write_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= write_target;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Parametrised gshare direction predictor with commit-time training.
// Define BP_BTB_EN to add the direct-mapped BTB for predicted targets.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned BTB_W  = 4
) (
  input  logic             clockIn,
  input  logic             resetIn,
  input  logic             readyIn,
  input  logic             predictReq,
  input  logic [AddrW-1:0] predictAddr,
  output logic             predictValid,
  output logic             predictTaken,
  output logic [IDX_W-1:0] predictIdx,
  output logic [AddrW-1:0] predictTarget,
  output logic             btbHit,
  input  logic             updateFlag,
  input  logic [IDX_W-1:0] updateIdx,
  input  logic [AddrW-1:0] updateAddr,
  input  logic             updateTaken,
  input  logic [AddrW-1:0] updateTarget
);

  localparam int unsigned PhtSize = 2 ** IDX_W;
  localparam cnt_t        CntInit = cnt_reset(CNT_W);
  localparam cnt_t        CntMax  = cnt_max(CNT_W);

  logic [CNT_W-1:0]  pht_q [PhtSize];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0]  lookup_idx;
  logic [CNT_W-1:0]  upd_cnt;
  logic              lookup_en, update_en;

  assign lookup_en  = readyIn && predictReq;
  assign update_en  = readyIn && updateFlag;
  assign lookup_idx = IDX_W'(gshare_hash(predictAddr, AddrW'(ghr_q), IDX_W));
  assign upd_cnt    = CNT_W'(cnt_step(cnt_t'(pht_q[updateIdx]), updateTaken, CntMax));
  // Shift form also works for a single-bit history.
  assign ghr_d      = (ghr_q << 1) | HIST_W'(updateTaken);

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int i = 0; i < PhtSize; i++) begin
        pht_q[i] <= CNT_W'(CntInit);
      end
      ghr_q <= '0;
    end else if (update_en) begin
      pht_q[updateIdx] <= upd_cnt;
      ghr_q            <= ghr_d;
    end
  end

  // Nonblocking reads here give read-before-write against the training port.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      predictValid <= 1'b0;
      predictTaken <= 1'b0;
      predictIdx   <= '0;
    end else if (lookup_en) begin
      predictValid <= 1'b1;
      predictTaken <= pht_q[lookup_idx][CNT_W-1];
      predictIdx   <= lookup_idx;
    end else if (readyIn) begin
      predictValid <= 1'b0;
    end
  end

`ifdef BP_BTB_EN
  gshare_predictor_btb #(
    .BTB_W(BTB_W)
  ) u_btb (
    .clk         (clockIn),
    .rst         (resetIn),
    .lookup_en   (lookup_en),
    .lookup_addr (predictAddr),
    .hit         (btbHit),
    .target      (predictTarget),
    .write_en    (update_en && updateTaken),
    .write_addr  (updateAddr),
    .write_target(updateTarget)
  );
`else
  localparam int unsigned unused_btb_w = BTB_W;
  logic unused_btb;

  assign btbHit        = 1'b0;
  assign predictTarget = '0;
  assign unused_btb    = ^{updateAddr, updateTarget};
`endif

endmodule
